// File: rtl/redirect_ctrl.sv
// EX-stage branch/jump resolution and front-end redirect controller.
// Detects mispredictions, holds the redirect PC until fetch accepts it, then masks wrong-path EX results.
module redirect_ctrl #(
   parameter int unsigned XLEN          = 32,
   parameter int unsigned SHADOW_CYCLES = 2,
   parameter int unsigned CNT_W         = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ex_valid,
   input  logic             ex_is_branch,
   input  logic             ex_is_jump,
   input  logic             ex_taken,
   input  logic             ex_pred_taken,
   input  logic [XLEN-1:0]  ex_pred_target,
   input  logic [XLEN-1:0]  ex_target,
   input  logic [XLEN-1:0]  ex_pc,
   input  logic             if_ready,
   output logic             flush,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             busy,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispredict_cnt
);

   localparam int unsigned SHW = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REDIR  = 2'd1,
      SHADOW = 2'd2
   } state_t;

   state_t         state;
   logic [SHW-1:0] shadow_cnt;

   logic            evaluate_c;
   logic            actual_taken_c;
   logic            mispredict_c;
   logic [XLEN-1:0] correct_pc_c;

   // Resolution logic; a jump flag dominates the branch direction
   always_comb begin
      evaluate_c     = ex_valid & (ex_is_branch | ex_is_jump) & (state == IDLE);
      actual_taken_c = ex_is_jump | ex_taken;
      mispredict_c   = evaluate_c &
                       ((actual_taken_c != ex_pred_taken) |
                        (actual_taken_c & ex_pred_taken & (ex_target != ex_pred_target)));
      correct_pc_c   = actual_taken_c ? ex_target : (ex_pc + XLEN'(4));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         shadow_cnt     <= '0;
         flush          <= 1'b0;
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         busy           <= 1'b0;
         branch_cnt     <= '0;
         mispredict_cnt <= '0;
      end else begin
         flush <= 1'b0;
         case (state)
            IDLE: begin
               if (evaluate_c && (branch_cnt != '1))
                  branch_cnt <= branch_cnt + CNT_W'(1);
               if (mispredict_c) begin
                  if (mispredict_cnt != '1)
                     mispredict_cnt <= mispredict_cnt + CNT_W'(1);
                  state          <= REDIR;
                  redirect_pc    <= correct_pc_c;
                  redirect_valid <= 1'b1;
                  flush          <= 1'b1;
                  busy           <= 1'b1;
               end
            end
            REDIR: begin
               if (if_ready) begin
                  state          <= SHADOW;
                  shadow_cnt     <= SHW'(SHADOW_CYCLES - 1);
                  redirect_valid <= 1'b0;
               end
            end
            SHADOW: begin
               if (shadow_cnt == '0) begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end else begin
                  shadow_cnt <= shadow_cnt - SHW'(1);
               end
            end
            default: begin
               state          <= IDLE;
               redirect_valid <= 1'b0;
               busy           <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_redirect_ctrl.sv
// Directed bench for redirect_ctrl; counters narrowed to 8 bits so saturation is reachable quickly.
module tb_redirect_ctrl;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned CNT_W = 8;

   logic             clk;
   logic             rst_n;
   logic             ex_valid;
   logic             ex_is_branch;
   logic             ex_is_jump;
   logic             ex_taken;
   logic             ex_pred_taken;
   logic [XLEN-1:0]  ex_pred_target;
   logic [XLEN-1:0]  ex_target;
   logic [XLEN-1:0]  ex_pc;
   logic             if_ready;
   logic             flush;
   logic             redirect_valid;
   logic [XLEN-1:0]  redirect_pc;
   logic             busy;
   logic [CNT_W-1:0] branch_cnt;
   logic [CNT_W-1:0] mispredict_cnt;

   int errors = 0;
   int checks = 0;

   redirect_ctrl #(.XLEN(XLEN), .SHADOW_CYCLES(2), .CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ex_valid       (ex_valid),
      .ex_is_branch   (ex_is_branch),
      .ex_is_jump     (ex_is_jump),
      .ex_taken       (ex_taken),
      .ex_pred_taken  (ex_pred_taken),
      .ex_pred_target (ex_pred_target),
      .ex_target      (ex_target),
      .ex_pc          (ex_pc),
      .if_ready       (if_ready),
      .flush          (flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .busy           (busy),
      .branch_cnt     (branch_cnt),
      .mispredict_cnt (mispredict_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic br, input logic jmp, input logic tk, input logic ptk,
                          input logic [31:0] ptgt, input logic [31:0] tgt, input logic [31:0] pc);
      ex_valid       = 1'b1;
      ex_is_branch   = br;
      ex_is_jump     = jmp;
      ex_taken       = tk;
      ex_pred_taken  = ptk;
      ex_pred_target = ptgt;
      ex_target      = tgt;
      ex_pc          = pc;
   endtask

   task automatic idle();
      ex_valid     = 1'b0;
      ex_is_branch = 1'b0;
      ex_is_jump   = 1'b0;
   endtask

   task automatic chk_ctl(input string tag, input logic f, input logic rv, input logic b);
      chk({tag, ".flush"}, 32'(flush), 32'(f));
      chk({tag, ".rv"},    32'(redirect_valid), 32'(rv));
      chk({tag, ".busy"},  32'(busy), 32'(b));
   endtask

   task automatic chk_cnt(input string tag, input int bc, input int mc);
      chk({tag, ".bcnt"}, 32'(branch_cnt), 32'(bc));
      chk({tag, ".mcnt"}, 32'(mispredict_cnt), 32'(mc));
   endtask

   initial begin
      rst_n = 1'b0; if_ready = 1'b0;
      ex_taken = 1'b0; ex_pred_taken = 1'b0;
      ex_pred_target = '0; ex_target = '0; ex_pc = '0;
      idle();

      // Reset state
      step(); step();
      chk_ctl("reset", 1'b0, 1'b0, 1'b0);
      chk("reset.rpc", redirect_pc, 32'h0);
      chk_cnt("reset", 0, 0);
      rst_n = 1'b1;
      step();

      // Correctly predicted not-taken branch
      present(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h100);
      step();
      chk_ctl("nt_ok", 1'b0, 1'b0, 1'b0);
      chk_cnt("nt_ok", 1, 0);

      // Taken branch predicted not-taken, accepted immediately; mispredicts held during busy
      if_ready = 1'b1;
      present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h200, 32'h180);
      step();
      chk_ctl("mp1_t1", 1'b1, 1'b1, 1'b1);
      chk("mp1_t1.rpc", redirect_pc, 32'h200);
      chk_cnt("mp1_t1", 2, 1);
      step();
      chk_ctl("mp1_t2", 1'b0, 1'b0, 1'b1);
      chk_cnt("mp1_t2", 2, 1);
      step();
      chk_ctl("mp1_t3", 1'b0, 1'b0, 1'b1);
      chk_cnt("mp1_t3", 2, 1);
      step();
      chk_ctl("mp1_t4", 1'b0, 1'b0, 1'b0);
      chk_cnt("mp1_t4", 2, 1);
      idle();
      step();
      chk_cnt("mp1_t5", 2, 1);

      // Predicted taken, resolves not-taken at top of address space: PC+4 wraps
      present(1'b1, 1'b0, 1'b0, 1'b1, 32'h1234, 32'h1234, 32'hFFFF_FFFC);
      step();
      chk_ctl("wrap", 1'b1, 1'b1, 1'b1);
      chk("wrap.rpc", redirect_pc, 32'h0);
      chk_cnt("wrap", 3, 2);
      idle();
      repeat (3) step();
      chk_ctl("wrap_done", 1'b0, 1'b0, 1'b0);

      // jalr with wrong predicted target, fetch stalls 3 cycles
      if_ready = 1'b0;
      present(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h340, 32'h2000);
      step();
      chk_ctl("jalr_t1", 1'b1, 1'b1, 1'b1);
      chk("jalr_t1.rpc", redirect_pc, 32'h340);
      chk_cnt("jalr_t1", 4, 3);
      idle();
      step();
      chk_ctl("jalr_t2", 1'b0, 1'b1, 1'b1);
      step();
      chk_ctl("jalr_t3", 1'b0, 1'b1, 1'b1);
      step();
      chk_ctl("jalr_t4", 1'b0, 1'b1, 1'b1);
      chk("jalr_t4.rpc", redirect_pc, 32'h340);
      if_ready = 1'b1;
      step();
      chk_ctl("jalr_t5", 1'b0, 1'b0, 1'b1);
      step();
      chk_ctl("jalr_t6", 1'b0, 1'b0, 1'b1);
      step();
      chk_ctl("jalr_t7", 1'b0, 1'b0, 1'b0);

      // Correctly predicted jump, and branch+jump both set treated as taken jump
      present(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h500, 32'h400);
      step();
      chk_ctl("jmp_ok", 1'b0, 1'b0, 1'b0);
      chk_cnt("jmp_ok", 5, 3);
      present(1'b1, 1'b1, 1'b0, 1'b1, 32'h600, 32'h600, 32'h404);
      step();
      chk_ctl("brjmp_ok", 1'b0, 1'b0, 1'b0);
      chk_cnt("brjmp_ok", 6, 3);

      // Invalid EX slot is not evaluated
      present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h700, 32'h408);
      ex_valid = 1'b0;
      step();
      chk_ctl("invalid", 1'b0, 1'b0, 1'b0);
      chk_cnt("invalid", 6, 3);

      // Drive counters into saturation
      for (int i = 0; i < 260; i++) begin
         present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h800, 32'h40C);
         step();
         idle();
         repeat (3) step();
      end
      chk_cnt("sat", 255, 255);
      present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h900, 32'h40C);
      step();
      chk_ctl("sat_more", 1'b1, 1'b1, 1'b1);
      chk("sat_more.rpc", redirect_pc, 32'h900);
      chk_cnt("sat_more", 255, 255);
      idle();
      repeat (3) step();

      // Asynchronous reset in the middle of REDIR
      if_ready = 1'b0;
      present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'hA00, 32'h500);
      step();
      chk_ctl("pre_rst", 1'b1, 1'b1, 1'b1);
      idle();
      #2 rst_n = 1'b0;
      #1;
      chk_ctl("mid_rst", 1'b0, 1'b0, 1'b0);
      chk("mid_rst.rpc", redirect_pc, 32'h0);
      chk_cnt("mid_rst", 0, 0);
      step();
      rst_n = 1'b1;
      step();
      chk_ctl("post_rst_idle", 1'b0, 1'b0, 1'b0);
      if_ready = 1'b1;
      present(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h780, 32'h600);
      step();
      chk_ctl("post_rst", 1'b1, 1'b1, 1'b1);
      chk("post_rst.rpc", redirect_pc, 32'h780);
      chk_cnt("post_rst", 1, 1);
      idle();
      repeat (3) step();
      chk_ctl("post_rst_done", 1'b0, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
